// File: rtl/store_split_unit.sv
// Store-path unit: turns one store request into one or two word-aligned
// DMEM write beats, splitting stores that straddle a word boundary.
module store_split_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wmask,
  output logic [XLEN-1:0]     mem_wdata,
  output logic                size_err,
  output logic [CNT_W-1:0]    split_count
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [NB-1:0]       mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
  logic [NB-1:0]       hi_wmask_q, hi_wmask_d;
  logic [XLEN-1:0]     hi_wdata_q, hi_wdata_d;
  logic                size_err_q, size_err_d;
  logic [CNT_W-1:0]    split_count_q, split_count_d;

  logic [OFF_W-1:0]    off;
  int unsigned         nbytes;
  logic                size_ok;
  logic [2*NB-1:0]     base_mask, wide_mask;
  logic [2*XLEN-1:0]   wide_shift, wide_data;
  logic [ADDR_W-1:0]   lo_addr;

  // Both beats are computed over a double-width window; the upper half is beat 1.
  always_comb begin
    off     = req_addr[OFF_W-1:0];
    nbytes  = 32'd1 << req_funct3[1:0];
    size_ok = !req_funct3[2] && ((req_funct3[1:0] != 2'd3) || (XLEN == 64));
    base_mask = '0;
    for (int unsigned i = 0; i < 2*NB; i++) begin
      if (i < nbytes) base_mask[i] = 1'b1;
    end
    wide_mask  = base_mask << off;
    wide_shift = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
    wide_data  = '0;
    for (int unsigned i = 0; i < 2*NB; i++) begin
      if (wide_mask[i]) wide_data[8*i +: 8] = wide_shift[8*i +: 8];
    end
    lo_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    state_d       = state_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_wmask_d   = mem_wmask_q;
    mem_wdata_d   = mem_wdata_q;
    hi_addr_d     = hi_addr_q;
    hi_wmask_d    = hi_wmask_q;
    hi_wdata_d    = hi_wdata_q;
    size_err_d    = 1'b0;
    split_count_d = split_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (size_ok) begin
            state_d     = S_BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = lo_addr;
            mem_wmask_d = wide_mask[NB-1:0];
            mem_wdata_d = wide_data[XLEN-1:0];
            hi_addr_d   = lo_addr + ADDR_W'(NB);
            hi_wmask_d  = wide_mask[2*NB-1:NB];
            hi_wdata_d  = wide_data[2*XLEN-1:XLEN];
          end else begin
            size_err_d = 1'b1;
          end
        end
      end
      S_BEAT0: begin
        if (mem_ready) begin
          if (hi_wmask_q != '0) begin
            state_d     = S_BEAT1;
            mem_addr_d  = hi_addr_q;
            mem_wmask_d = hi_wmask_q;
            mem_wdata_d = hi_wdata_q;
            if (split_count_q != '1) split_count_d = split_count_q + CNT_W'(1);
          end else begin
            state_d     = S_IDLE;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_wmask_d = '0;
            mem_wdata_d = '0;
          end
        end
      end
      S_BEAT1: begin
        if (mem_ready) begin
          state_d     = S_IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_wmask_d = '0;
          mem_wdata_d = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wmask_q   <= '0;
      mem_wdata_q   <= '0;
      hi_addr_q     <= '0;
      hi_wmask_q    <= '0;
      hi_wdata_q    <= '0;
      size_err_q    <= 1'b0;
      split_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wmask_q   <= mem_wmask_d;
      mem_wdata_q   <= mem_wdata_d;
      hi_addr_q     <= hi_addr_d;
      hi_wmask_q    <= hi_wmask_d;
      hi_wdata_q    <= hi_wdata_d;
      size_err_q    <= size_err_d;
      split_count_q <= split_count_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_wdata   = mem_wdata_q;
  assign size_err    = size_err_q;
  assign split_count = split_count_q;

endmodule

// File: tb/tb_store_split_unit.sv
// Randomized bench for store_split_unit against a byte-level queue model.
module tb_store_split_unit;

  localparam int unsigned CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        size_err;
  logic [CNT_W-1:0] split_count;

  store_split_unit #(.XLEN(32), .ADDR_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .size_err(size_err), .split_count(split_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];
  int    m_cnt;
  logic  m_err;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each byte k of the store lands at address addr+k; group bytes by word.
  task automatic model_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    beat_t b0, b1;
    logic [31:0] ba;
    int nb, lane;
    nb = 1 << f3[1:0];
    b0.addr = a & ~32'h3; b0.mask = '0; b0.data = '0;
    b1.addr = b0.addr + 32'd4; b1.mask = '0; b1.data = '0;
    for (int k = 0; k < nb; k++) begin
      ba   = a + 32'(k);
      lane = int'(ba[1:0]);
      if ((ba & ~32'h3) == b0.addr) begin
        b0.mask[lane] = 1'b1;
        b0.data[8*lane +: 8] = d[8*k +: 8];
      end else begin
        b1.mask[lane] = 1'b1;
        b1.data[8*lane +: 8] = d[8*k +: 8];
      end
    end
    q.push_back(b0);
    if (b1.mask != 4'b0) q.push_back(b1);
  endtask

  task automatic cycle(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic rst);
    req_valid = v; req_funct3 = f3; req_addr = a; req_wdata = d;
    mem_ready = rdy; rst_n = rst;
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_cnt = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (q.size() == 0) begin
        if (v) begin
          if (f3[2] || f3[1:0] == 2'd3) m_err = 1'b1;
          else model_req(f3, a, d);
        end
      end else if (rdy) begin
        void'(q.pop_front());
        if (q.size() != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
    #1;
    check("req_ready", 64'(req_ready), 64'(q.size() == 0));
    check("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      check("mem_wmask", 64'(mem_wmask), 64'(q[0].mask));
      check("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
    end
    if (!rst) begin
      check("rst_addr", 64'(mem_addr), 64'd0);
      check("rst_wmask", 64'(mem_wmask), 64'd0);
      check("rst_wdata", 64'(mem_wdata), 64'd0);
    end
    check("size_err", 64'(size_err), 64'(m_err));
    check("split_count", 64'(split_count), 64'(m_cnt));
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, rdy, 1'b1);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, f3, a, d, 1'b1, 1'b1);
    for (int i = 0; i < 4 && q.size() != 0; i++) idle(1'b1);
  endtask

  initial begin
    q.delete(); m_cnt = 0; m_err = 1'b0;
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 32'h55, 32'h1, 1'b1, 1'b0);
    check("reset_ready", 64'(req_ready), 64'd1);

    // 1: aligned SW
    cycle(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1);
    check("t1_addr", 64'(mem_addr), 64'h100);
    check("t1_mask", 64'(mem_wmask), 64'hF);
    check("t1_data", 64'(mem_wdata), 64'hDEADBEEF);
    idle(1'b1);
    check("t1_ready_back", 64'(req_ready), 64'd1);

    // 2: SB in top lane
    store(3'd0, 32'h103, 32'h000000AB);
    check("t2_count", 64'(split_count), 64'd0);

    // 3: SH crossing words
    cycle(1'b1, 3'd1, 32'h203, 32'h00001234, 1'b1, 1'b1);
    check("t3_b0_data", 64'(mem_wdata), 64'h34000000);
    idle(1'b1);
    check("t3_b1_addr", 64'(mem_addr), 64'h204);
    check("t3_b1_data", 64'(mem_wdata), 64'h12);
    check("t3_count", 64'(split_count), 64'd1);
    idle(1'b1);

    // 4: split SW with backpressure on each beat
    cycle(1'b1, 3'd2, 32'h102, 32'hDEADBEEF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("t4_b0_mask", 64'(mem_wmask), 64'hC);
    idle(1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("t4_b1_data", 64'(mem_wdata), 64'h0000DEAD);
    idle(1'b1);

    // 5: address wrap, then reset in BEAT1
    cycle(1'b1, 3'd2, 32'hFFFFFFFE, 32'h11223344, 1'b1, 1'b1);
    idle(1'b1);
    check("t5_wrap_addr", 64'(mem_addr), 64'h0);
    check("t5_wrap_mask", 64'(mem_wmask), 64'h3);
    check("t5_count_sat", 64'(split_count), 64'd3);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("t5_rst_valid", 64'(mem_valid), 64'd0);
    idle(1'b1);
    idle(1'b1);

    // 6: illegal size, then saturation from zero
    cycle(1'b1, 3'd3, 32'h300, 32'h12345678, 1'b1, 1'b1);
    check("t6_err", 64'(size_err), 64'd1);
    idle(1'b1);
    check("t6_err_drop", 64'(size_err), 64'd0);
    cycle(1'b1, 3'd6, 32'h300, 32'h12345678, 1'b1, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 5; i++) store(3'd2, 32'h401 + 32'(8*i), 32'hCAFEF00D);
    check("t6_count_sat", 64'(split_count), 64'd3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 9) < 6), f3, $urandom, $urandom,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
